// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: validates decoded NEC frames, classifies them as new key / repeat / error,
// and drives smg with either the live frame or a 4-deep command history.
// Optional macro IR_HIST_CLR_EN: CLR_KEY clears the history and the error count.
module ir_cmd_ctrl #(
  parameter logic [7:0]  DEV_ADDR    = 8'h00,
  parameter bit          ADDR_FILTER = 1'b1,
  parameter logic [7:0]  MODE_KEY    = 8'h45,
  parameter logic [7:0]  CLR_KEY     = 8'h47,
  parameter int unsigned REPEAT_WIN  = 5_500_000
) (
  input  logic        CLOCK_50,
  input  logic        s_rst_n,
  input  logic [31:0] ir_data,
  input  logic        ir_data_vld,
  output logic [31:0] disp_data,
  output logic        disp_vld,
  output logic [7:0]  key_code,
  output logic        key_vld,
  output logic        key_repeat,
  output logic        mode,
  output logic [7:0]  err_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned TMR_W = (REPEAT_WIN < 1) ? 1 : $clog2(REPEAT_WIN + 1);

`ifdef IR_HIST_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ACCEPT,
    S_REJECT,
    S_UPDATE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_frame, w_frame_nxt;
  logic [31:0]        r_hist, w_hist_nxt;
  logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
  logic               r_key_seen, w_key_seen_nxt;
  logic [31:0]        r_disp_data, w_disp_data_nxt;
  logic               r_disp_vld, w_disp_vld_nxt;
  logic [7:0]         r_key_code, w_key_code_nxt;
  logic               r_key_vld, w_key_vld_nxt;
  logic               r_key_repeat, w_key_repeat_nxt;
  logic               r_mode, w_mode_nxt;
  logic [7:0]         r_err_cnt, w_err_cnt_nxt;
  logic [7:0]         r_drop_cnt, w_drop_cnt_nxt;

  logic [7:0] w_addr, w_addr_n, w_cmd, w_cmd_n;
  logic       w_ok, w_is_rpt;

  assign w_addr   = r_frame[7:0];
  assign w_addr_n = r_frame[15:8];
  assign w_cmd    = r_frame[23:16];
  assign w_cmd_n  = r_frame[31:24];

  assign w_ok = (w_addr == ~w_addr_n) && (w_cmd == ~w_cmd_n) &&
                (!ADDR_FILTER || (w_addr == DEV_ADDR));

  // Same command inside the repeat window, and only once a key has ever been accepted
  assign w_is_rpt = r_key_seen && (w_cmd == r_key_code) && (r_tmr != '0);

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_frame_nxt      = r_frame;
    w_hist_nxt       = r_hist;
    w_tmr_nxt        = (r_tmr != '0) ? r_tmr - TMR_W'(1) : r_tmr;
    w_key_seen_nxt   = r_key_seen;
    w_disp_data_nxt  = r_disp_data;
    w_disp_vld_nxt   = 1'b0;
    w_key_code_nxt   = r_key_code;
    w_key_vld_nxt    = 1'b0;
    w_key_repeat_nxt = 1'b0;
    w_mode_nxt       = r_mode;
    w_err_cnt_nxt    = r_err_cnt;
    w_drop_cnt_nxt   = r_drop_cnt;

    if (ir_data_vld && (r_state != S_IDLE) && (r_drop_cnt != 8'hFF))
      w_drop_cnt_nxt = r_drop_cnt + 8'd1;

    case (r_state)
      S_IDLE: begin
        if (ir_data_vld) begin
          w_frame_nxt = ir_data;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_nxt = w_ok ? S_ACCEPT : S_REJECT;
      end
      S_ACCEPT: begin
        w_tmr_nxt = TMR_W'(REPEAT_WIN);
        if (w_is_rpt) begin
          w_key_repeat_nxt = 1'b1;
        end else begin
          w_key_vld_nxt  = 1'b1;
          w_key_code_nxt = w_cmd;
          w_key_seen_nxt = 1'b1;
          if (w_cmd == MODE_KEY)
            w_mode_nxt = ~r_mode;
          if (CLR_EN && (w_cmd == CLR_KEY)) begin
            w_hist_nxt    = '0;
            w_err_cnt_nxt = '0;
          end else begin
            w_hist_nxt = {r_hist[23:0], w_cmd};
          end
        end
        w_state_nxt = S_UPDATE;
      end
      S_REJECT: begin
        if (r_err_cnt != 8'hFF)
          w_err_cnt_nxt = r_err_cnt + 8'd1;
        w_state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        // r_mode/r_hist already carry any change made in ACCEPT
        w_disp_data_nxt = r_mode ? r_hist : r_frame;
        w_disp_vld_nxt  = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLOCK_50 or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state      <= S_IDLE;
      r_frame      <= '0;
      r_hist       <= '0;
      r_tmr        <= '0;
      r_key_seen   <= 1'b0;
      r_disp_data  <= '0;
      r_disp_vld   <= 1'b0;
      r_key_code   <= '0;
      r_key_vld    <= 1'b0;
      r_key_repeat <= 1'b0;
      r_mode       <= 1'b0;
      r_err_cnt    <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame      <= w_frame_nxt;
      r_hist       <= w_hist_nxt;
      r_tmr        <= w_tmr_nxt;
      r_key_seen   <= w_key_seen_nxt;
      r_disp_data  <= w_disp_data_nxt;
      r_disp_vld   <= w_disp_vld_nxt;
      r_key_code   <= w_key_code_nxt;
      r_key_vld    <= w_key_vld_nxt;
      r_key_repeat <= w_key_repeat_nxt;
      r_mode       <= w_mode_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_drop_cnt   <= w_drop_cnt_nxt;
    end
  end

  assign disp_data  = r_disp_data;
  assign disp_vld   = r_disp_vld;
  assign key_code   = r_key_code;
  assign key_vld    = r_key_vld;
  assign key_repeat = r_key_repeat;
  assign mode       = r_mode;
  assign err_cnt    = r_err_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// tb_ir_cmd_ctrl: table vectors, corner sequences and random frames for ir_cmd_ctrl,
// checked against a transaction-level model of keys, history, mode and counters.
module tb_ir_cmd_ctrl;

  localparam int unsigned WIN    = 40;
  localparam logic [7:0]  MODE_K = 8'h45;
  localparam logic [7:0]  CLR_K  = 8'h47;
`ifdef IR_HIST_CLR_EN
  localparam bit CLR_ON = 1'b1;
`else
  localparam bit CLR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir_data;
  logic        ir_vld;

  logic [31:0] disp_data, nf_disp;
  logic        disp_vld, nf_dvld;
  logic [7:0]  key_code, nf_code;
  logic        key_vld, nf_kvld;
  logic        key_repeat, nf_krep;
  logic        mode, nf_mode;
  logic [7:0]  err_cnt, nf_err;
  logic [7:0]  drop_cnt, nf_drop;

  always #10 clk = ~clk;

  ir_cmd_ctrl #(.DEV_ADDR(8'h00), .ADDR_FILTER(1'b1), .MODE_KEY(MODE_K),
                .CLR_KEY(CLR_K), .REPEAT_WIN(WIN)) dut (
    .CLOCK_50(clk), .s_rst_n(rst_n), .ir_data(ir_data), .ir_data_vld(ir_vld),
    .disp_data(disp_data), .disp_vld(disp_vld), .key_code(key_code),
    .key_vld(key_vld), .key_repeat(key_repeat), .mode(mode),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt));

  ir_cmd_ctrl #(.DEV_ADDR(8'h00), .ADDR_FILTER(1'b0), .MODE_KEY(MODE_K),
                .CLR_KEY(CLR_K), .REPEAT_WIN(WIN)) dut_nf (
    .CLOCK_50(clk), .s_rst_n(rst_n), .ir_data(ir_data), .ir_data_vld(ir_vld),
    .disp_data(nf_disp), .disp_vld(nf_dvld), .key_code(nf_code),
    .key_vld(nf_kvld), .key_repeat(nf_krep), .mode(nf_mode),
    .err_cnt(nf_err), .drop_cnt(nf_drop));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: what has been accepted, not how the FSM gets there
  logic [7:0] m_code;
  bit         m_seen;
  logic [7:0] m_hist [4];
  bit         m_mode;
  int         m_err;
  int         m_drop;
  int         m_last_acc;

  function automatic void model_reset();
    m_code = 8'h00; m_seen = 1'b0; m_mode = 1'b0;
    m_err = 0; m_drop = 0; m_last_acc = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
  endfunction

  function automatic logic [31:0] hist_word();
    return {m_hist[3], m_hist[2], m_hist[1], m_hist[0]};
  endfunction

  logic       cap_kvld, cap_krep, cap_mode, cap_nf_kvld;
  logic [7:0] cap_code, cap_err, cap_nf_code;
  logic [31:0] cap_disp;

  // Send one frame after 'gap' idle cycles; 'extra' more strobes land while busy
  task automatic run_frame(input logic [31:0] d, input int gap, input int extra);
    logic [7:0] a, an, c, cn;
    bit ok, rep, e_kvld, e_krep;
    int v;
    logic [31:0] e_disp;
    repeat (gap) begin @(posedge clk); #1; end
    ir_data = d;
    ir_vld  = 1'b1;
    @(posedge clk); #1;
    v = cyc;
    {cn, c, an, a} = d;
    ok = (an == ~a) && (cn == ~c) && (a == 8'h00);
    e_kvld = 1'b0; e_krep = 1'b0;
    if (ok) begin
      rep = m_seen && (c == m_code) && ((v - m_last_acc) <= int'(WIN));
      m_last_acc = v;
      if (rep) e_krep = 1'b1;
      else begin
        e_kvld = 1'b1; m_code = c; m_seen = 1'b1;
        if (c == MODE_K) m_mode = !m_mode;
        if (CLR_ON && (c == CLR_K)) begin
          for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
          m_err = 0;
        end else begin
          for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = c;
        end
      end
    end else if (m_err < 255) m_err++;
    m_drop = (m_drop + extra > 255) ? 255 : m_drop + extra;
    e_disp = m_mode ? hist_word() : d;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      ir_vld = (k <= extra);
      if (k < 3) chk("early_strobes", 32'({key_vld, key_repeat, disp_vld}), 32'h0);
      if (k == 3) begin
        cap_kvld = key_vld; cap_krep = key_repeat; cap_code = key_code;
        cap_mode = mode; cap_err = err_cnt;
        cap_nf_kvld = nf_kvld; cap_nf_code = nf_code;
        chk("key_vld", 32'(key_vld), 32'(e_kvld));
        chk("key_repeat", 32'(key_repeat), 32'(e_krep));
        chk("key_code", 32'(key_code), 32'(m_code));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("disp_vld_early", 32'(disp_vld), 32'h0);
      end
      if (k == 4) begin
        cap_disp = disp_data;
        chk("disp_vld", 32'(disp_vld), 32'h1);
        chk("disp_data", disp_data, e_disp);
        chk("key_strobe_width", 32'({key_vld, key_repeat}), 32'h0);
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      end
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("quiet_strobes", 32'({key_vld, key_repeat, disp_vld}), 32'h0);
    end
  endtask

  task automatic rand_frame();
    logic [7:0] c, a;
    logic [31:0] d;
    case ($urandom_range(0, 5))
      0: c = MODE_K;
      1: c = CLR_K;
      2: c = 8'h18;
      3: c = 8'h19;
      default: c = 8'($urandom);
    endcase
    a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
    d = {~c, c, ~a, a};
    if ($urandom_range(0, 6) == 0) d[31:24] = d[31:24] ^ 8'($urandom_range(1, 255));
    run_frame(d, int'($urandom_range(0, 60)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
  endtask

  typedef struct {
    logic [31:0] d;
    int          gap;
    bit          kvld;
    bit          krep;
    logic [7:0]  code;
    bit          md;
    logic [7:0]  err;
    logic [31:0] disp;
    bit          nf;
    logic [7:0]  nf_code;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{32'hBA45FF00, 0,  1'b1, 1'b0, 8'h45, 1'b1, 8'h00, 32'h00000045, 1'b0, 8'h00};
    tbl[1]  = '{32'hBA45FF00, 10, 1'b0, 1'b1, 8'h45, 1'b1, 8'h00, 32'h00000045, 1'b0, 8'h00};
    tbl[2]  = '{32'hBA45FF00, 60, 1'b1, 1'b0, 8'h45, 1'b0, 8'h00, 32'hBA45FF00, 1'b0, 8'h00};
    tbl[3]  = '{32'hBA44FF00, 0,  1'b0, 1'b0, 8'h45, 1'b0, 8'h01, 32'hBA44FF00, 1'b0, 8'h00};
    tbl[4]  = '{32'hE718FE01, 0,  1'b0, 1'b0, 8'h45, 1'b0, 8'h02, 32'hE718FE01, 1'b1, 8'h18};
    tbl[5]  = '{32'hE718FF00, 0,  1'b1, 1'b0, 8'h18, 1'b0, 8'h02, 32'hE718FF00, 1'b0, 8'h00};
    tbl[6]  = '{32'hE619FF00, 0,  1'b1, 1'b0, 8'h19, 1'b0, 8'h02, 32'hE619FF00, 1'b0, 8'h00};
    tbl[7]  = '{32'hE51AFF00, 0,  1'b1, 1'b0, 8'h1A, 1'b0, 8'h02, 32'hE51AFF00, 1'b0, 8'h00};
    tbl[8]  = '{32'hE41BFF00, 0,  1'b1, 1'b0, 8'h1B, 1'b0, 8'h02, 32'hE41BFF00, 1'b0, 8'h00};
    tbl[9]  = '{32'hBA45FF00, 0,  1'b1, 1'b0, 8'h45, 1'b1, 8'h02, 32'h191A1B45, 1'b0, 8'h00};
`ifdef IR_HIST_CLR_EN
    tbl[10] = '{32'hB847FF00, 0,  1'b1, 1'b0, 8'h47, 1'b1, 8'h00, 32'h00000000, 1'b0, 8'h00};
`else
    tbl[10] = '{32'hB847FF00, 0,  1'b1, 1'b0, 8'h47, 1'b1, 8'h02, 32'h1A1B4547, 1'b0, 8'h00};
`endif

    rst_n = 1'b0; ir_vld = 1'b0; ir_data = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_disp_data", disp_data, 32'h0);
    chk("rst_outputs", 32'({key_code, err_cnt, drop_cnt, mode, key_vld, key_repeat, disp_vld}), 32'h0);
    rst_n = 1'b1;
    quiet(2);

    for (int i = 0; i < NV; i++) begin
      run_frame(tbl[i].d, tbl[i].gap, 0);
      chk($sformatf("tbl%0d_kvld", i), 32'(cap_kvld), 32'(tbl[i].kvld));
      chk($sformatf("tbl%0d_krep", i), 32'(cap_krep), 32'(tbl[i].krep));
      chk($sformatf("tbl%0d_code", i), 32'(cap_code), 32'(tbl[i].code));
      chk($sformatf("tbl%0d_mode", i), 32'(cap_mode), 32'(tbl[i].md));
      chk($sformatf("tbl%0d_err", i), 32'(cap_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_disp", i), cap_disp, tbl[i].disp);
      if (tbl[i].nf) begin
        chk($sformatf("tbl%0d_nofilter_kvld", i), 32'(cap_nf_kvld), 32'h1);
        chk($sformatf("tbl%0d_nofilter_code", i), 32'(cap_nf_code), 32'(tbl[i].nf_code));
      end
    end

    // Strobe one cycle after a frame: dropped, one frame processed
    run_frame(32'hE619FF00, 0, 1);
    chk("drop_one", 32'(drop_cnt), 32'h1);
    quiet(5);

    // Repeat window boundary: delta == WIN repeats, WIN+1 is a new key
    run_frame(32'hE619FF00, 0, 0);
    run_frame(32'hE619FF00, int'(WIN) - 4, 0);
    chk("win_edge_repeat", 32'(cap_krep), 32'h1);
    run_frame(32'hE619FF00, int'(WIN) - 3, 0);
    chk("win_past_new", 32'(cap_kvld), 32'h1);

    // Saturate the error counter
    for (int i = 0; i < 260; i++) run_frame(32'hBA44FF00, 0, 0);
    chk("err_saturate", 32'(err_cnt), 32'hFF);

    // Reset while in CHECK: all outputs clear, nothing emitted afterwards
    ir_data = 32'hBA45FF00; ir_vld = 1'b1;
    @(posedge clk); #1;
    ir_vld = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_disp_data", disp_data, 32'h0);
    chk("midrst_outputs", 32'({key_code, err_cnt, drop_cnt, mode, key_vld, key_repeat, disp_vld}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    quiet(8);

    for (int i = 0; i < 300; i++) rand_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
